// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings and
// the quotient fill pattern returned on a zero divisor.
package div_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ZERO = 3'd1;
  localparam logic [2:0] BUSY = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // Every quotient bit is set when the divisor is zero
  localparam logic DIV_ZERO_QUOT = 1'b1;

endpackage

// File: rtl/div_multicycle_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_multicycle_if #(
  parameter int unsigned WIDTH = 32
);

  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 finish_o;
  logic                 busy_o;
  logic                 div_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, finish_o, busy_o, div_zero_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, finish_o, busy_o, div_zero_o
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem, quo} shift register.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep the difference if no borrow.
  // rem_in < divisor always holds, so a borrow shows up exactly in diff[WIDTH].
  always_comb begin
    partial = {rem_in, quo_in[WIDTH-1]};
    diff    = partial - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_out = partial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_multicycle.sv
// Multi-cycle restoring integer divider (signed/unsigned), STEPS quotient
// bits per clock. Result is {remainder, quotient} plus a divide-by-zero flag.
module div_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 1
) (
  input logic              clk,
  input logic              rst,
  div_multicycle_if.slave  bus
);

  import div_pkg::*;

  if ((WIDTH % 2 != 0) || (WIDTH < 4) || !(STEPS == 1 || STEPS == 2 || STEPS == 4) ||
      (WIDTH % STEPS != 0)) begin : g_bad_params
    $error("div_multicycle: illegal WIDTH/STEPS combination");
  end

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - STEPS);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo;
  logic             neg_rem;

  logic             sgn1;
  logic             sgn2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  logic [WIDTH-1:0] rem_c [0:STEPS];
  logic [WIDTH-1:0] quo_c [0:STEPS];

  // Operand magnitudes; |MIN| = 2^(WIDTH-1) fits as an unsigned value
  always_comb begin
    sgn1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    sgn2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    mag1 = sgn1 ? -bus.opdata1_i : bus.opdata1_i;
    mag2 = sgn2 ? -bus.opdata2_i : bus.opdata2_i;
  end

  // Sign restoration: remainder follows the dividend's sign
  always_comb begin
    quo_fix = neg_quo ? -quo_q : quo_q;
    rem_fix = neg_rem ? -rem_q : rem_q;
  end

  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_c[i]),
      .quo_in  (quo_c[i]),
      .divisor (dvs_q),
      .rem_out (rem_c[i+1]),
      .quo_out (quo_c[i+1])
    );
  end

  assign bus.busy_o = (state != IDLE);

  // Control FSM, iteration counter, working registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      neg_quo        <= 1'b0;
      neg_rem        <= 1'b0;
      bus.result_o   <= '0;
      bus.finish_o   <= 1'b0;
      bus.div_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.result_o   <= '0;
          bus.finish_o   <= 1'b0;
          bus.div_zero_o <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= ZERO;
            end else begin
              state   <= BUSY;
              cnt     <= '0;
              rem_q   <= '0;
              quo_q   <= mag1;
              dvs_q   <= mag2;
              neg_quo <= sgn1 ^ sgn2;
              neg_rem <= sgn1;
            end
          end
        end
        ZERO: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            state          <= DONE;
            bus.result_o   <= {bus.opdata1_i, {WIDTH{DIV_ZERO_QUOT}}};
            bus.finish_o   <= 1'b1;
            bus.div_zero_o <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            rem_q <= rem_c[STEPS];
            quo_q <= quo_c[STEPS];
            cnt   <= cnt + CNT_INC;
            if (cnt == CNT_LAST) state <= FIX;
          end
        end
        FIX: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            state          <= DONE;
            bus.result_o   <= {rem_fix, quo_fix};
            bus.finish_o   <= 1'b1;
            bus.div_zero_o <= 1'b0;
          end
        end
        DONE: begin
          if (!bus.start_i) begin
            state          <= IDLE;
            bus.result_o   <= '0;
            bus.finish_o   <= 1'b0;
            bus.div_zero_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_multicycle.sv
// Bench for div_multicycle: three instances (STEPS = 1, 2, 4) at WIDTH = 32 share
// one stimulus stream; expected results come from a 64-bit arithmetic model.
module tb_div_multicycle;

  logic        clk;
  logic        rst;
  logic        sd;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;

  logic [63:0] res [3];
  logic        fin [3];
  logic        bsy [3];
  logic        dz  [3];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    bit          zero;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    div_multicycle_if #(.WIDTH(32)) bus ();
    assign bus.signed_div_i = sd;
    assign bus.opdata1_i    = op1;
    assign bus.opdata2_i    = op2;
    assign bus.start_i      = start;
    assign bus.annul_i      = annul;
    assign res[g] = bus.result_o;
    assign fin[g] = bus.finish_o;
    assign bsy[g] = bus.busy_o;
    assign dz[g]  = bus.div_zero_o;
    div_multicycle #(.WIDTH(32), .STEPS(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic int steps_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  // {div_zero, remainder, quotient} computed with wide signed arithmetic
  function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Drive one request, measure latency on every instance, compare against the scoreboard
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t        e;
    logic [64:0] m;
    int          lat [3];
    int          exp_lat;
    m      = model(s, a, b);
    e.res  = m[63:0];
    e.dz   = m[64];
    e.zero = (b == 32'd0);
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    sd = s; op1 = a; op2 = b; start = 1'b1;
    for (int g = 0; g < 3; g++) lat[g] = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) if (fin[g] && lat[g] == 0) lat[g] = n;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    @(negedge clk);
    e = sb_q.pop_front();
    for (int g = 0; g < 3; g++) begin
      exp_lat = e.zero ? 2 : 32 / steps_of(g) + 2;
      n_checks++;
      if (lat[g] !== exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency steps=%0d: got %0d edges, expected %0d", e.name, steps_of(g), lat[g], exp_lat);
      end
      n_checks++;
      if (res[g] !== e.res) begin
        n_fail++;
        $display("FAIL %s_result steps=%0d: got %h, expected %h", e.name, steps_of(g), res[g], e.res);
      end
      n_checks++;
      if (dz[g] !== e.dz || fin[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_flags steps=%0d: got dz=%b fin=%b, expected dz=%b fin=1", e.name, steps_of(g), dz[g], fin[g], e.dz);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (fin[g] !== 1'b0 || bsy[g] !== 1'b0 || dz[g] !== 1'b0 || res[g] !== 64'd0) begin
        n_fail++;
        $display("FAIL %s_release steps=%0d: got fin=%b busy=%b dz=%b res=%h, expected all zero",
                 e.name, steps_of(g), fin[g], bsy[g], dz[g], res[g]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; sd = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (fin[g] !== 1'b0 || bsy[g] !== 1'b0 || dz[g] !== 1'b0 || res[g] !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_state steps=%0d: got fin=%b busy=%b dz=%b res=%h, expected all zero",
                 steps_of(g), fin[g], bsy[g], dz[g], res[g]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    do_op(1'b0, 32'd100, 32'd7, "udiv_100_7");
    do_op(1'b0, 32'hFFFF_FFFF, 32'd3, "udiv_max_3");
    do_op(1'b0, 32'd5, 32'd9, "udiv_small");
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "udiv_big_divisor");
  endtask

  task automatic test_signed();
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv_m7_2");
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, "sdiv_7_m2");
    do_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "sdiv_m7_m2");
  endtask

  task automatic test_div_zero();
    do_op(1'b0, 32'h0000_1234, 32'd0, "zero_u");
    do_op(1'b1, 32'hFFFF_FFFB, 32'd0, "zero_s");
  endtask

  task automatic test_overflow();
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_min_m1");
    do_op(1'b1, 32'h8000_0000, 32'd1, "min_1");
  endtask

  task automatic test_annul();
    bit seen;
    @(negedge clk);
    sd = 1'b0; op1 = 32'd5; op2 = 32'd1; start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (bsy[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL annul_idle_block steps=%0d: got busy=%b, expected 0", steps_of(g), bsy[g]);
      end
    end
    @(negedge clk);
    annul = 1'b0; op1 = 32'd1000; op2 = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (bsy[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL annul_busy_before steps=%0d: got busy=%b, expected 1", steps_of(g), bsy[g]);
      end
    end
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (bsy[g] !== 1'b0 || fin[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL annul_busy_drop steps=%0d: got busy=%b fin=%b, expected 0 0", steps_of(g), bsy[g], fin[g]);
      end
    end
    @(negedge clk);
    annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) if (fin[g]) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_no_finish: got finish seen=%b, expected 0", seen);
    end
    do_op(1'b0, 32'd9, 32'd3, "annul_followup");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sd = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (bsy[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_busy_before steps=%0d: got busy=%b, expected 1", steps_of(g), bsy[g]);
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (fin[g] !== 1'b0 || bsy[g] !== 1'b0 || dz[g] !== 1'b0 || res[g] !== 64'd0) begin
        n_fail++;
        $display("FAIL rst_mid_busy steps=%0d: got fin=%b busy=%b dz=%b res=%h, expected all zero",
                 steps_of(g), fin[g], bsy[g], dz[g], res[g]);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // Zero-divisor result held in DONE: annul is ignored there, reset still clears it
    @(negedge clk);
    sd = 1'b0; op1 = 32'h0000_1234; op2 = 32'd0; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (fin[g] !== 1'b1 || res[g] !== 64'h0000_1234_FFFF_FFFF) begin
        n_fail++;
        $display("FAIL done_annul_ignored steps=%0d: got fin=%b res=%h, expected fin=1 res=0000_1234_ffff_ffff",
                 steps_of(g), fin[g], res[g]);
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (fin[g] !== 1'b0 || dz[g] !== 1'b0 || res[g] !== 64'd0) begin
        n_fail++;
        $display("FAIL rst_in_done steps=%0d: got fin=%b dz=%b res=%h, expected all zero",
                 steps_of(g), fin[g], dz[g], res[g]);
      end
    end
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 32'd81, 32'd9, "b2b_first");
    do_op(1'b1, 32'hFFFF_FF9C, 32'd10, "b2b_second");
  endtask

  task automatic test_random();
    logic        s;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: b = $urandom;
      endcase
      do_op(s, a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
